// File: rtl/uv_bus_arb.sv
// Round-robin arbiter that shares one req/rsp slave port among NUM masters,
// with exactly one transaction in flight from grant through response.
module uv_bus_arb #(
  parameter int ALEN = 12,
  parameter int DLEN = 32,
  parameter int MLEN = DLEN / 8,
  parameter int NUM  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM-1:0]       m_req_vld,
  output logic [NUM-1:0]       m_req_rdy,
  input  logic [NUM-1:0]       m_req_read,
  input  logic [NUM*ALEN-1:0]  m_req_addr,
  input  logic [NUM*MLEN-1:0]  m_req_mask,
  input  logic [NUM*DLEN-1:0]  m_req_data,
  output logic [NUM-1:0]       m_rsp_vld,
  input  logic [NUM-1:0]       m_rsp_rdy,
  output logic [NUM*2-1:0]     m_rsp_excp,
  output logic [NUM*DLEN-1:0]  m_rsp_data,
  output logic                 s_req_vld,
  input  logic                 s_req_rdy,
  output logic                 s_req_read,
  output logic [ALEN-1:0]      s_req_addr,
  output logic [MLEN-1:0]      s_req_mask,
  output logic [DLEN-1:0]      s_req_data,
  input  logic                 s_rsp_vld,
  output logic                 s_rsp_rdy,
  input  logic [1:0]           s_rsp_excp,
  input  logic [DLEN-1:0]      s_rsp_data
);

  localparam int GW = (NUM > 1) ? $clog2(NUM) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [GW-1:0] gnt_r;
  logic [GW-1:0] gnt_s;
  logic [GW-1:0] ptr_r;
  logic [GW-1:0] ptr_s;

  // Lowest requester at or after ptr, wrapping; walking downward lets the
  // closest candidate to ptr overwrite the farther ones.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM-1:0] vld,
                                            input logic [GW-1:0]  ptr);
    logic [GW:0]   sum;
    logic [GW:0]   lim;
    logic [GW-1:0] idx;
    logic [GW-1:0] sel;
    sel = ptr;
    lim = (GW + 1)'(NUM);
    for (int k = NUM - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (GW + 1)'(k);
      idx = (sum >= lim) ? GW'(sum - lim) : sum[GW-1:0];
      sel = vld[idx] ? idx : sel;
    end
    return sel;
  endfunction

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      gnt_r   <= {GW{1'b0}};
      ptr_r   <= {GW{1'b0}};
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      ptr_r   <= ptr_s;
    end
  end

  // Next-state, grant selection and pointer advance.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    ptr_s   = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (|m_req_vld) begin
          gnt_s   = rr_pick(m_req_vld, ptr_r);
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (s_req_vld && s_req_rdy) begin
          state_s = ST_RSP;
        end else if (!m_req_vld[gnt_r]) begin
          // Granted master withdrew: release without advancing the pointer.
          state_s = ST_IDLE;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_RSP: begin
        if (s_rsp_vld && s_rsp_rdy) begin
          ptr_s   = (gnt_r == GW'(NUM - 1)) ? {GW{1'b0}} : gnt_r + 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RSP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Bus routing: request mux toward the slave, response demux toward the
  // granted master; master ready never depends on m_rsp_rdy.
  always_comb begin
    m_req_rdy  = {NUM{1'b0}};
    m_rsp_vld  = {NUM{1'b0}};
    m_rsp_excp = {(NUM * 2){1'b0}};
    m_rsp_data = {(NUM * DLEN){1'b0}};
    s_req_vld  = 1'b0;
    s_req_read = 1'b0;
    s_req_addr = {ALEN{1'b0}};
    s_req_mask = {MLEN{1'b0}};
    s_req_data = {DLEN{1'b0}};
    s_rsp_rdy  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        s_req_vld = 1'b0;
      end
      ST_REQ: begin
        s_req_vld        = m_req_vld[gnt_r];
        s_req_read       = m_req_read[gnt_r];
        s_req_addr       = m_req_addr[int'(gnt_r) * ALEN +: ALEN];
        s_req_mask       = m_req_mask[int'(gnt_r) * MLEN +: MLEN];
        s_req_data       = m_req_data[int'(gnt_r) * DLEN +: DLEN];
        m_req_rdy[gnt_r] = s_req_rdy;
      end
      ST_RSP: begin
        m_rsp_vld[gnt_r]                         = s_rsp_vld;
        m_rsp_excp[int'(gnt_r) * 2 +: 2]         = s_rsp_excp;
        m_rsp_data[int'(gnt_r) * DLEN +: DLEN]   = s_rsp_data;
        s_rsp_rdy                                = m_rsp_rdy[gnt_r];
      end
      default: begin
        s_req_vld = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uv_bus_arb.sv
// Bench for uv_bus_arb (NUM=2): table of single-master transactions plus
// hand-written sequences for back-to-back, stalled response, reset and withdrawal.
module tb_uv_bus_arb;

  localparam int ALEN = 12;
  localparam int DLEN = 32;
  localparam int MLEN = 4;
  localparam int NUM  = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         m_req_vld;
  logic [1:0]         m_req_rdy;
  logic [1:0]         m_req_read;
  logic [11:0]        addr_m [2];
  logic [3:0]         mask_m [2];
  logic [31:0]        wdata_m [2];
  logic [23:0]        m_req_addr;
  logic [7:0]         m_req_mask;
  logic [63:0]        m_req_data;
  logic [1:0]         m_rsp_vld;
  logic [1:0]         m_rsp_rdy;
  logic [3:0]         m_rsp_excp;
  logic [63:0]        m_rsp_data;
  logic               s_req_vld;
  logic               s_req_rdy;
  logic               s_req_read;
  logic [11:0]        s_req_addr;
  logic [3:0]         s_req_mask;
  logic [31:0]        s_req_data;
  logic               s_rsp_vld;
  logic               s_rsp_rdy;
  logic [1:0]         s_rsp_excp;
  logic [31:0]        s_rsp_data;

  assign m_req_addr = {addr_m[1], addr_m[0]};
  assign m_req_mask = {mask_m[1], mask_m[0]};
  assign m_req_data = {wdata_m[1], wdata_m[0]};

  always #5 clk = ~clk;

  uv_bus_arb #(.ALEN(ALEN), .DLEN(DLEN), .MLEN(MLEN), .NUM(NUM)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy), .m_req_read(m_req_read),
    .m_req_addr(m_req_addr), .m_req_mask(m_req_mask), .m_req_data(m_req_data),
    .m_rsp_vld(m_rsp_vld), .m_rsp_rdy(m_rsp_rdy), .m_rsp_excp(m_rsp_excp),
    .m_rsp_data(m_rsp_data),
    .s_req_vld(s_req_vld), .s_req_rdy(s_req_rdy), .s_req_read(s_req_read),
    .s_req_addr(s_req_addr), .s_req_mask(s_req_mask), .s_req_data(s_req_data),
    .s_rsp_vld(s_rsp_vld), .s_rsp_rdy(s_rsp_rdy), .s_rsp_excp(s_rsp_excp),
    .s_rsp_data(s_rsp_data)
  );

  typedef struct {
    int          m;
    logic        rd;
    logic [11:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  excp;
    int          rdy_wait;
  } vec_t;

  typedef struct {
    int          m;
    logic [31:0] data;
    logic [1:0]  excp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ptr_m   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [1:0] vld, input int ptr);
    int i;
    for (int k = 0; k < 2; k++) begin
      i = (ptr + k) % 2;
      if (vld[i]) return i;
    end
    return -1;
  endfunction

  function automatic int obs_gnt(input logic [1:0] r);
    case (r)
      2'b01:   return 0;
      2'b10:   return 1;
      default: return -1;
    endcase
  endfunction

  function automatic logic [127:0] all_out();
    return {m_req_rdy, m_rsp_vld, m_rsp_excp, m_rsp_data, s_req_vld, s_rsp_rdy,
            s_req_read, s_req_addr, s_req_mask, s_req_data};
  endfunction

  // One full transaction starting at posedge+1 in IDLE with m_req_vld already driven.
  task automatic run_txn(input logic [31:0] rdata, input logic [1:0] excp,
                         input int rdy_wait, input bit drop, output int gnt_obs);
    int   m;
    int   mi;
    exp_t e;
    exp_t got;
    m  = model_pick(m_req_vld, ptr_m);
    mi = (m < 0) ? 0 : m;
    e.m = mi; e.data = rdata; e.excp = excp;
    sb.push_back(e);
    s_req_rdy = 1'b1; s_rsp_vld = 1'b0; m_rsp_rdy = 2'b11;
    #1;
    check("idle_s_req_vld", s_req_vld, 1'b0);
    check("idle_m_req_rdy", m_req_rdy, 2'b00);
    @(posedge clk); #2;
    gnt_obs = obs_gnt(m_req_rdy);
    check("req_grant", gnt_obs, m);
    check("req_s_vld", s_req_vld, 1'b1);
    check("req_read", s_req_read, m_req_read[mi]);
    check("req_addr", s_req_addr, addr_m[mi]);
    check("req_mask", s_req_mask, mask_m[mi]);
    check("req_data", s_req_data, wdata_m[mi]);
    check("req_s_rsp_rdy", s_rsp_rdy, 1'b0);
    @(posedge clk); #1;
    if (drop) m_req_vld[mi] = 1'b0;
    s_rsp_vld = 1'b1; s_rsp_data = rdata; s_rsp_excp = excp;
    m_rsp_rdy[mi] = (rdy_wait == 0);
    for (int w = 0; w < rdy_wait; w++) begin
      #1;
      check("hold_s_rsp_rdy", s_rsp_rdy, 1'b0);
      check("hold_m_req_rdy", m_req_rdy, 2'b00);
      check("hold_s_req_vld", s_req_vld, 1'b0);
      check("hold_m_rsp_vld", m_rsp_vld, 2'b01 << mi);
      @(posedge clk); #1;
    end
    m_rsp_rdy = 2'b11;
    #1;
    check("rsp_m_vld", m_rsp_vld, 2'b01 << mi);
    check("rsp_s_rdy", s_rsp_rdy, 1'b1);
    check("rsp_m_req_rdy", m_req_rdy, 2'b00);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("rsp_data", m_rsp_data, 64'(got.data) << (32 * got.m));
      check("rsp_excp", m_rsp_excp, 4'(got.excp) << (2 * got.m));
    end else begin
      check("sb_underflow", sb.size(), 1);
    end
    @(posedge clk); #1;
    s_rsp_vld = 1'b0;
    ptr_m = (mi + 1) % 2;
  endtask

  // Grant m1 (ptr must be 1), keep the slave busy, then m1 withdraws.
  task automatic withdraw_m1();
    m_req_vld = 2'b11; s_req_rdy = 1'b0;
    @(posedge clk); #2;
    check("wd_m_req_rdy", m_req_rdy, 2'b00);
    check("wd_s_vld", s_req_vld, 1'b1);
    check("wd_addr", s_req_addr, addr_m[1]);
    m_req_vld[1] = 1'b0;
    #1;
    check("wd_drop_s_vld", s_req_vld, 1'b0);
    @(posedge clk); #1;
    s_req_rdy = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    m_req_vld = 2'b11; s_rsp_vld = 1'b1; s_req_rdy = 1'b1; m_rsp_rdy = 2'b11;
    @(negedge clk);
    check("reset_outputs", all_out(), 128'd0);
    repeat (2) @(negedge clk);
    m_req_vld = 2'b00; s_rsp_vld = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ptr_m = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tab[5];
    int   g;
    tab[0] = '{0, 1'b1, 12'h004, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF, 2'd0, 0};
    tab[1] = '{1, 1'b0, 12'hFFC, 4'h3, 32'h1234_5678, 32'h0000_0000, 2'd2, 0};
    tab[2] = '{0, 1'b0, 12'h000, 4'h8, 32'hA5A5_A5A5, 32'h0000_0000, 2'd1, 0};
    tab[3] = '{1, 1'b1, 12'h800, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 2'd3, 2};
    tab[4] = '{0, 1'b1, 12'h7FF, 4'h1, 32'h0000_0000, 32'h0000_0001, 2'd0, 0};

    m_req_vld = 2'b00; m_req_read = 2'b00; m_rsp_rdy = 2'b11;
    s_req_rdy = 1'b0; s_rsp_vld = 1'b0; s_rsp_excp = 2'd0; s_rsp_data = 32'd0;
    for (int i = 0; i < 2; i++) begin
      addr_m[i] = 12'd0; mask_m[i] = 4'd0; wdata_m[i] = 32'd0;
    end
    do_reset();

    for (int i = 0; i < 5; i++) begin
      m_req_vld = 2'b00;
      addr_m[tab[i].m]  = tab[i].addr;
      mask_m[tab[i].m]  = tab[i].mask;
      wdata_m[tab[i].m] = tab[i].wdata;
      m_req_read[tab[i].m] = tab[i].rd;
      m_req_vld[tab[i].m]  = 1'b1;
      run_txn(tab[i].rdata, tab[i].excp, tab[i].rdy_wait, 1'b1, g);
      check("tab_grant", g, tab[i].m);
    end

    // Both masters request continuously from ptr=0: grants must alternate 0,1,...
    do_reset();
    addr_m[0] = 12'h111; addr_m[1] = 12'h222;
    mask_m[0] = 4'h5;    mask_m[1] = 4'hA;
    wdata_m[0] = 32'h0101_0101; wdata_m[1] = 32'h0202_0202;
    m_req_read = 2'b10;
    m_req_vld = 2'b11;
    for (int k = 0; k < 6; k++) begin
      run_txn(32'h1000_0000 + 32'(k), 2'(k), (k == 2) ? 5 : 0, 1'b0, g);
      check("b2b_grant", g, k % 2);
    end

    // Serve m0 (ptr -> 1), then reset while m1's response is pending.
    m_req_vld = 2'b01;
    run_txn(32'h3333_3333, 2'd0, 0, 1'b1, g);
    m_req_vld = 2'b10; s_req_rdy = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    s_rsp_vld = 1'b1; s_rsp_data = 32'h4444_4444; m_rsp_rdy = 2'b00; m_req_vld = 2'b11;
    #1;
    check("pre_rst_rsp_vld", m_rsp_vld, 2'b10);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", all_out(), 128'd0);
    @(negedge clk);
    rst_n = 1'b1; m_req_vld = 2'b00; s_rsp_vld = 1'b0; m_rsp_rdy = 2'b11;
    @(posedge clk); #1;
    ptr_m = 0;
    m_req_vld = 2'b11;
    run_txn(32'h5555_5555, 2'd1, 0, 1'b1, g);
    check("rst_ptr_grant", g, 0);

    // Withdrawal keeps ptr at 1: m1 wins a fresh tie, m0 wins when alone.
    withdraw_m1();
    m_req_vld = 2'b11;
    run_txn(32'h6666_6666, 2'd2, 0, 1'b1, g);
    check("wd_tie_grant", g, 1);
    m_req_vld = 2'b01;
    run_txn(32'h7777_7777, 2'd0, 0, 1'b1, g);
    withdraw_m1();
    m_req_vld = 2'b01;
    run_txn(32'h8888_8888, 2'd3, 0, 1'b1, g);
    check("wd_pending_grant", g, 0);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
